// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its buffer.
// The optional performance counters in instruction_fetch are enabled by IFETCH_PERF_EN.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF   = 10;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Canonical ADDI x0,x0,0; decode substitutes it for squashed slots.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs; the head is a dedicated register
// so decode sees a stable, glitch-free word. Flush empties it in one cycle.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_entry_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  buf_state_e   state_q, state_d;
  fetch_entry_t head_q, head_d;
  fetch_entry_t tail_q, tail_d;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (push_i) begin
            head_d  = push_entry_i;
            state_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          case ({push_i, pop_i})
            2'b10: begin
              tail_d  = push_entry_i;
              state_d = BUF_FULL;
            end
            2'b01: state_d = BUF_EMPTY;
            2'b11: head_d  = push_entry_i;
            default: ;
          endcase
        end
        BUF_FULL: begin
          // The upstream credit check never pushes into a full buffer without a pop.
          if (pop_i) begin
            head_d = tail_q;
            if (push_i) begin
              tail_d = push_entry_i;
            end else begin
              state_d = BUF_ONE;
            end
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign count_o = state_q;
  assign head_o  = head_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: drives a synchronous-read instruction memory, tracks the one-cycle
// read latency and queues words for decode. Define IFETCH_PERF_EN for perf counters.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [31:0]       instruction,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  logic [31:0]  fetchPc_q, fetchPc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflightPc_q, inflightPc_d;

  logic         pop, push, issue;
  logic [2:0]   occupancy;
  logic [1:0]   bufCount;
  fetch_entry_t pushEntry;
  fetch_entry_t headEntry;
  logic         unusedBits;

  assign unusedBits = ^redirect_pc[1:0];

  assign if_valid = (bufCount != 2'd0);
  assign pop      = if_valid && if_ready;

  // Words already buffered plus the one in flight must leave room for the next issue.
  assign occupancy = {1'b0, bufCount} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = !redirect_valid && (occupancy < 3'd2);
  assign push      = inflight_q && !redirect_valid;

  assign pushEntry.pc    = inflightPc_q;
  assign pushEntry.instr = instruction;

  always_comb begin
    fetchPc_d    = fetchPc_q;
    inflight_d   = 1'b0;
    inflightPc_d = inflightPc_q;
    if (redirect_valid) begin
      fetchPc_d = {redirect_pc[31:2], 2'b00};
    end else if (issue) begin
      inflight_d   = 1'b1;
      inflightPc_d = fetchPc_q;
      fetchPc_d    = fetchPc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc_q    <= RESET_PC;
      inflight_q   <= 1'b0;
      inflightPc_q <= '0;
    end else begin
      fetchPc_q    <= fetchPc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
    end
  end

  fetch_buffer u_buffer (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .push_entry_i (pushEntry),
    .count_o      (bufCount),
    .head_o       (headEntry)
  );

  assign read_addr = fetchPc_q[ADDR_W+1:2];
  assign if_instr  = headEntry.instr;
  assign if_pc     = headEntry.pc;

`ifdef IFETCH_PERF_EN
  logic [31:0] perfFetched_q, perfFetched_d;
  logic [31:0] perfStall_q, perfStall_d;

  always_comb begin
    perfFetched_d = perfFetched_q;
    perfStall_d   = perfStall_q;
    if (pop) begin
      perfFetched_d = perfFetched_q + 32'd1;
    end
    if (if_valid && !if_ready) begin
      perfStall_d = perfStall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perfFetched_q <= '0;
      perfStall_q   <= '0;
    end else begin
      perfFetched_q <= perfFetched_d;
      perfStall_q   <= perfStall_d;
    end
  end

  assign perf_fetched = perfFetched_q;
  assign perf_stall   = perfStall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch with a synchronous-read memory model.
module tb_instruction_fetch;

  localparam logic [31:0] I0 = 32'h0011_00B3;
  localparam logic [31:0] I1 = 32'h0011_0133;
  localparam logic [31:0] I2 = 32'h0011_01B3;
  localparam logic [31:0] I3 = 32'h0011_7233;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  read_addr;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  // Synchronous-read memory: word for the address seen at an edge appears after it.
  always @(posedge clk) instruction <= mem[read_addr];

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .read_addr      (read_addr),
    .instruction    (instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] redirPc;
    logic        ready;
    logic [9:0]  expAddr;
    logic        expValid;
    logic        chkData;
    logic [31:0] expPc;
    logic [31:0] expInstr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] w(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic addVec(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                        input logic [9:0] ea, input logic ev, input logic cd,
                        input logic [31:0] epc, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.redir = rv; v.redirPc = rpc; v.ready = rdy;
    v.expAddr = ea; v.expValid = ev; v.chkData = cd; v.expPc = epc; v.expInstr = ei;
    vecs.push_back(v);
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are driven mid-cycle so the next rising edge samples them.
  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [9:0] ea, input logic ev, input logic cd,
                             input logic [31:0] epc, input logic [31:0] ei);
    checkVal({tag, " read_addr"}, 32'(read_addr), 32'(ea));
    checkVal({tag, " if_valid"}, 32'(if_valid), 32'(ev));
    if (ev || cd) begin
      checkVal({tag, " if_pc"}, if_pc, epc);
      checkVal({tag, " if_instr"}, if_instr, ei);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = w(i);
    mem[0] = I0; mem[1] = I1; mem[2] = I2; mem[3] = I3;

    // rst rdir rpc  rdy addr vld chk pc  instr
    for (int i = 0; i < 3; i++) addVec(1, 0, 0, 1, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 1, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 2, 1, 0, 32'h0, I0);
    addVec(0, 0, 0, 1, 3, 1, 0, 32'h4, I1);
    addVec(0, 0, 0, 1, 4, 1, 0, 32'h8, I2);
    for (int i = 0; i < 5; i++) addVec(0, 0, 0, 0, 5, 1, 0, 32'hC, I3);
    addVec(0, 0, 0, 1, 5, 1, 0, 32'hC, I3);
    addVec(0, 0, 0, 1, 6, 1, 0, 32'h10, w(4));
    addVec(0, 0, 0, 1, 7, 1, 0, 32'h14, w(5));
    addVec(0, 0, 0, 0, 8, 1, 0, 32'h18, w(6));
    addVec(0, 1, 32'h8, 0, 8, 1, 0, 32'h18, w(6));
    addVec(0, 0, 0, 1, 2, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 3, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 4, 1, 0, 32'h8, I2);
    addVec(0, 1, 32'hFFF, 1, 5, 1, 0, 32'hC, I3);
    addVec(0, 0, 0, 1, 10'd1023, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 1, 1, 0, 32'hFFC, w(1023));
    addVec(0, 0, 0, 1, 2, 1, 0, 32'h1000, I0);
    addVec(0, 0, 0, 0, 3, 1, 0, 32'h1004, I1);
    addVec(1, 0, 0, 0, 3, 1, 0, 32'h1004, I1);
    addVec(0, 0, 0, 1, 0, 0, 1, 32'h0, 32'h0);
    addVec(0, 0, 0, 1, 1, 0, 0, 0, 0);
    addVec(0, 0, 0, 1, 2, 1, 0, 32'h0, I0);
    addVec(0, 0, 0, 1, 3, 1, 0, 32'h4, I1);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].redir, vecs[i].redirPc, vecs[i].ready);
      checkOutput($sformatf("vec%0d", i), vecs[i].expAddr, vecs[i].expValid,
                  vecs[i].chkData, vecs[i].expPc, vecs[i].expInstr);
    end

    // Redirect during a pop with a word in flight; low PC bits must be ignored.
    applyStimulus(0, 1, 32'h23, 1);
    checkOutput("redir c0", 4, 1, 0, 32'h8, I2);
    applyStimulus(0, 0, 0, 1);
    checkOutput("redir c1", 8, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("redir c2", 9, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("redir c3", 10, 1, 0, 32'h20, w(8));
    applyStimulus(0, 0, 0, 1);
    checkOutput("redir c4", 11, 1, 0, 32'h24, w(9));

`ifdef IFETCH_PERF_EN
    applyStimulus(1, 0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 0, (k == 5 || k == 6) ? 1'b0 : 1'b1);
      if (k == 0) begin
        checkVal("perf reset fetched", perf_fetched, 32'd0);
        checkVal("perf reset stall", perf_stall, 32'd0);
        checkVal("perf reset valid", 32'(if_valid), 32'd0);
      end
      if (k == 5) begin
        checkVal("perf fetched3", perf_fetched, 32'd3);
        checkVal("perf stall0", perf_stall, 32'd0);
      end
      if (k == 7) begin
        checkVal("perf fetched hold", perf_fetched, 32'd3);
        checkVal("perf stall2", perf_stall, 32'd2);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
